// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the CPU (port 0) and
// the debug/loader (port 1), in the CPU clock domain.
//
// Default arbitration in IDLE is fixed priority to port 0, with a wait counter
// that forces port 1 through after MAX_WAIT consecutive denied cycles.
// A granted access with lockx = 1 parks ownership on port x (OWNx) for bursts.
//
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration in IDLE.
// In that build MAX_WAIT is ignored and no wait counter is built.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req/lock/we/addr/wdata 0,1 requester inputs (held stable until gnt)
//   gnt0, gnt1                 access accepted this cycle (combinational)
//   rvalid0/1, rdata0/1        read return, one cycle after the granted read
//   mem_we/mem_addr/mem_data   to the memory; all 0 when nothing is granted
//   mem_out                    registered read data from the memory
//   owner                      debug: 00 idle, 01 port 0 locked, 10 port 1 locked
module mem_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_out,
    output logic [1:0]            owner
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] OWN0 = 2'b01;
    localparam logic [1:0] OWN1 = 2'b10;

    logic [1:0] state_q, state_d;
    logic       win0, win1;

`ifdef MEM_ARB_RR_EN
    // last_q = 1 means port 1 won most recently; reset to 1 so port 0 wins
    // the first tie.
    logic last_q;

    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    win0 = last_q;
                    win1 = !last_q;
                end else begin
                    win0 = req0;
                    win1 = req1;
                end
            end
            OWN0:    win0 = req0;
            OWN1:    win1 = req1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    last_q <= 1'b1;
        else if (win0) last_q <= 1'b0;
        else if (win1) last_q <= 1'b1;
    end
`else
    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    logic [3:0] wait_q;
    logic       starve;

    assign starve = (wait_q == MAX_W);

    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        case (state_q)
            IDLE: begin
                if (req1 && starve) win1 = 1'b1;
                else if (req0)      win0 = 1'b1;
                else if (req1)      win1 = 1'b1;
            end
            OWN0:    win0 = req0;
            OWN1:    win1 = req1;
            default: ;
        endcase
    end

    // Counts denied port-1 cycles in any state (including OWN0); the force
    // only matters in IDLE, so it naturally applies once the lock drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              wait_q <= '0;
        else if (!req1 || win1)  wait_q <= '0;
        else if (!starve)        wait_q <= wait_q + 4'd1;
    end
`endif

    assign gnt0  = win0;
    assign gnt1  = win1;
    assign owner = state_q;

    // Memory side muxed from the winner; zero when idle so the bus is quiet.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        if (win0) begin
            mem_we   = we0;
            mem_addr = addr0;
            mem_data = wdata0;
        end else if (win1) begin
            mem_we   = we1;
            mem_addr = addr1;
            mem_data = wdata1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (win0)      state_d = lock0 ? OWN0 : IDLE;
        else if (win1) state_d = lock1 ? OWN1 : IDLE;
        else begin
            case (state_q)
                OWN0:    if (!req0 && !lock0) state_d = IDLE;
                OWN1:    if (!req1 && !lock1) state_d = IDLE;
                IDLE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Read-owner register: which port's read is returning this cycle.
    logic                  rv0_q, rv1_q;
    logic [DATA_WIDTH-1:0] rd0_q, rd1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv0_q <= 1'b0;
            rv1_q <= 1'b0;
        end else begin
            rv0_q <= win0 && !we0;
            rv1_q <= win1 && !we1;
        end
    end

    // mem_out is valid during the return cycle; it is passed through then
    // and captured at the end of that cycle so rdata holds until the next
    // read by the same port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd0_q <= '0;
            rd1_q <= '0;
        end else begin
            if (rv0_q) rd0_q <= mem_out;
            if (rv1_q) rd1_q <= mem_out;
        end
    end

    assign rvalid0 = rv0_q;
    assign rvalid1 = rv1_q;
    assign rdata0  = rv0_q ? mem_out : rd0_q;
    assign rdata1  = rv1_q ? mem_out : rd1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, lock0, lock1, we0, we1;
    logic [5:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [15:0] rdata0, rdata1, mem_data, mem_out;
    logic [5:0]  mem_addr;
    logic [1:0]  owner;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_out(mem_out), .owner(owner)
    );

    // Behavioural single-port memory: write at the edge, registered read.
    logic [15:0] mem [0:63];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[1] = 16'h0011;
        mem[2] = 16'h0022;
        mem_out = 16'h0000;
    end
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data;
        mem_out <= mem[mem_addr];
    end

    typedef struct {
        logic        r0, r1, l0, l1, w0, w1;
        logic [5:0]  a0, a1;
        logic [15:0] d0, d1;
        logic        g0, g1, mwe;
        logic [5:0]  ma;
        logic [15:0] md;
        logic [1:0]  own;
        logic        rv0, rv1;
        logic [15:0] rd0, rd1;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req0 = v.r0; req1 = v.r1; lock0 = v.l0; lock1 = v.l1;
        we0 = v.w0; we1 = v.w1; addr0 = v.a0; addr1 = v.a1;
        wdata0 = v.d0; wdata1 = v.d1;
    endtask

    task automatic idle_in();
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    initial begin
        logic g1e;
        idle_in();
        rst_n = 1'b0;

        // Table: inputs | g0 g1 mwe maddr mdata owner rv0 rv1 rdata0 rdata1
        vt.push_back('{0,0,0,0,0,0, 6'd0,6'd0, 16'h0,16'h0,       0,0,0, 6'd0, 16'h0,    2'd0, 0,0, 16'h0,16'h0});
        vt.push_back('{1,0,0,0,1,0, 6'd5,6'd0, 16'hBEEF,16'h0,    1,0,1, 6'd5, 16'hBEEF, 2'd0, 0,0, 16'h0,16'h0});
        vt.push_back('{1,0,0,0,0,0, 6'd5,6'd0, 16'h0,16'h0,       1,0,0, 6'd5, 16'h0,    2'd0, 0,0, 16'h0,16'h0});
        vt.push_back('{0,0,0,0,0,0, 6'd0,6'd0, 16'h0,16'h0,       0,0,0, 6'd0, 16'h0,    2'd0, 1,0, 16'hBEEF,16'h0});
        vt.push_back('{0,0,0,0,0,0, 6'd0,6'd0, 16'h0,16'h0,       0,0,0, 6'd0, 16'h0,    2'd0, 0,0, 16'hBEEF,16'h0});
        // pipelined reads, alternating ports
        vt.push_back('{1,0,0,0,0,0, 6'd1,6'd0, 16'h0,16'h0,       1,0,0, 6'd1, 16'h0,    2'd0, 0,0, 16'hBEEF,16'h0});
        vt.push_back('{0,1,0,0,0,0, 6'd0,6'd2, 16'h0,16'h0,       0,1,0, 6'd2, 16'h0,    2'd0, 1,0, 16'h0011,16'h0});
        vt.push_back('{0,0,0,0,0,0, 6'd0,6'd0, 16'h0,16'h0,       0,0,0, 6'd0, 16'h0,    2'd0, 0,1, 16'h0011,16'h0022});
        // contention: both ports write continuously
        for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_RR_EN
            g1e = (k % 2 == 1);
`else
            g1e = (k == 4);
`endif
            vt.push_back('{1,1,0,0,1,1, 6'd3,6'd4, 16'h0A0A,16'h0B0B,
                           !g1e, g1e, 1, g1e ? 6'd4 : 6'd3, g1e ? 16'h0B0B : 16'h0A0A,
                           2'd0, 0,0, 16'h0011,16'h0022});
        end
        vt.push_back('{0,0,0,0,0,0, 6'd0,6'd0, 16'h0,16'h0,       0,0,0, 6'd0, 16'h0,    2'd0, 0,0, 16'h0011,16'h0022});
        // lock burst by port 1 (addrs 10..13), port 0 requesting from the 2nd beat
        vt.push_back('{0,1,0,1,0,1, 6'd3,6'd10, 16'h0A0A,16'h1010, 0,1,1, 6'd10, 16'h1010, 2'd0, 0,0, 16'h0011,16'h0022});
        vt.push_back('{1,1,0,1,1,1, 6'd3,6'd11, 16'h0A0A,16'h1111, 0,1,1, 6'd11, 16'h1111, 2'd2, 0,0, 16'h0011,16'h0022});
        vt.push_back('{1,1,0,1,1,1, 6'd3,6'd12, 16'h0A0A,16'h1212, 0,1,1, 6'd12, 16'h1212, 2'd2, 0,0, 16'h0011,16'h0022});
        vt.push_back('{1,1,0,0,1,1, 6'd3,6'd13, 16'h0A0A,16'h1313, 0,1,1, 6'd13, 16'h1313, 2'd2, 0,0, 16'h0011,16'h0022});
        vt.push_back('{1,0,0,0,1,0, 6'd3,6'd0,  16'h0A0A,16'h0,    1,0,1, 6'd3,  16'h0A0A, 2'd0, 0,0, 16'h0011,16'h0022});
        vt.push_back('{0,0,0,0,0,0, 6'd0,6'd0, 16'h0,16'h0,        0,0,0, 6'd0,  16'h0,    2'd0, 0,0, 16'h0011,16'h0022});
        // read back a burst word
        vt.push_back('{1,0,0,0,0,0, 6'd12,6'd0, 16'h0,16'h0,       1,0,0, 6'd12, 16'h0,    2'd0, 0,0, 16'h0011,16'h0022});
        vt.push_back('{0,0,0,0,0,0, 6'd0,6'd0, 16'h0,16'h0,        0,0,0, 6'd0,  16'h0,    2'd0, 1,0, 16'h1212,16'h0022});

        // Reset state
        #3;
        chk("rst.gnt0", 32'(gnt0), 32'd0);
        chk("rst.gnt1", 32'(gnt1), 32'd0);
        chk("rst.mem_we", 32'(mem_we), 32'd0);
        chk("rst.mem_addr", 32'(mem_addr), 32'd0);
        chk("rst.owner", 32'(owner), 32'd0);
        chk("rst.rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        chk("rst.rdata", 32'({rdata0, rdata1}), 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vt[i]) begin
            drive(vt[i]);
            #1;
            chk($sformatf("v%0d.gnt0", i), 32'(gnt0), 32'(vt[i].g0));
            chk($sformatf("v%0d.gnt1", i), 32'(gnt1), 32'(vt[i].g1));
            chk($sformatf("v%0d.mem_we", i), 32'(mem_we), 32'(vt[i].mwe));
            chk($sformatf("v%0d.mem_addr", i), 32'(mem_addr), 32'(vt[i].ma));
            chk($sformatf("v%0d.mem_data", i), 32'(mem_data), 32'(vt[i].md));
            chk($sformatf("v%0d.owner", i), 32'(owner), 32'(vt[i].own));
            chk($sformatf("v%0d.rvalid0", i), 32'(rvalid0), 32'(vt[i].rv0));
            chk($sformatf("v%0d.rvalid1", i), 32'(rvalid1), 32'(vt[i].rv1));
            chk($sformatf("v%0d.rdata0", i), 32'(rdata0), 32'(vt[i].rd0));
            chk($sformatf("v%0d.rdata1", i), 32'(rdata1), 32'(vt[i].rd1));
            @(posedge clk); #1;
        end

        // Reset mid-burst: port 1 locked read of addr 2 outstanding
        idle_in();
        req1 = 1; lock1 = 1; addr1 = 6'd2;
        #1 chk("mid.gnt1", 32'(gnt1), 32'd1);
        @(posedge clk); #1;
        req1 = 0;
        #1;
        chk("mid.owner_pre", 32'(owner), 32'd2);
        chk("mid.rvalid1_pre", 32'(rvalid1), 32'd1);
        chk("mid.rdata1_pre", 32'(rdata1), 32'h0022);
        rst_n = 1'b0;
        #1;
        chk("mid.rvalid1_rst", 32'(rvalid1), 32'd0);
        chk("mid.owner_rst", 32'(owner), 32'd0);
        chk("mid.rdata1_rst", 32'(rdata1), 32'd0);
        #1 rst_n = 1'b1;
        lock1 = 0;
        req0 = 1; we0 = 0; addr0 = 6'd1;
        #1 chk("post.gnt0", 32'(gnt0), 32'd1);
        chk("post.gnt1", 32'(gnt1), 32'd0);
        @(posedge clk); #1;
        idle_in();
        #1;
        chk("post.rvalid0", 32'(rvalid0), 32'd1);
        chk("post.rdata0", 32'(rdata0), 32'h0011);
        chk("post.owner", 32'(owner), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
